// File: rtl/fu_result_buffer.sv
// Per-FU result FIFO feeding the common-data-bus output selector.
// Holds completed (value, tag) pairs in order and retires the head on a matching grant.
`timescale 1ns/1ps

module fu_result_buffer #(
  parameter int FU_ID  = 0,
  parameter int CAT    = 0,
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int FU_CAT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  input  logic              fu_done,
  input  logic [DATA_W-1:0] fu_value,
  input  logic [TAG_W-1:0]  fu_tag,
  output logic              fu_ready,
  input  logic [4:0]        fu_num,
  input  logic [FU_CAT-1:0] cat_select,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_value,
  output logic [TAG_W-1:0]  result_tag,
  output logic              overflow_err
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [FU_CAT-1:0] CAT_MASK = FU_CAT'(1) << CAT;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head_entry;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             cat_hit, grant, push, pop;

  // Ready depends only on registered count, never on this cycle's grant.
  assign fu_ready     = (count_q < FULL_CNT);
  assign result_valid = (count_q != '0);

  assign cat_hit = |(cat_select & CAT_MASK);
  assign grant   = result_valid && cat_hit && (fu_num == 5'(FU_ID));
  assign push    = fu_done && fu_ready && !squash;
  assign pop     = grant && !squash;

  assign head_entry   = mem_q[head_q];
  assign result_value = head_entry.value;
  assign result_tag   = head_entry.tag;
  assign overflow_err = overflow_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | (fu_done && !fu_ready && !squash);

    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers wrap for free because DEPTH is a power of two.
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[tail_q] <= entry_t'{value: fu_value, tag: fu_tag};
  end

endmodule
